branch_predict_unit: RTL and testbench

//  Parametrised branch prediction and resolution unit for the RV32 pipeline.

---
 rtl/branch_predict_unit.sv | 107 ++++++++++
 tb/tb_branch_predict_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: BHT predictor and B-type branch resolver; define BPU_STATS_EN to enable the stat counters
module branch_predict_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CTR_BITS    = 2,
    parameter int PC_LSB      = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_valid,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pred_taken,
    output logic            bpu_ready,
    input  logic            res_valid,
    input  logic [31:0]     res_inst,
    input  logic [XLEN-1:0] res_pc,
    input  logic            res_pred_taken,
    input  logic            cmp_eq,
    input  logic            cmp_lt,
    input  logic            cmp_ltu,
    input  logic [3:0]      select_mode,
    output logic [1:0]      pc_sel,
    output logic            mispredict,
    output logic            flush,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);
    localparam int IDXW = $clog2(BHT_ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [IDXW-1:0] LAST = IDXW'(BHT_ENTRIES - 1);
    typedef enum logic {INIT, RUN} state_t;
    state_t state, state_nx;
    logic [IDXW-1:0] ptr, fidx, ridx;
    logic [CTR_BITS-1:0] bht [BHT_ENTRIES];
    logic [CTR_BITS-1:0] rctr, rctr_nx;
    logic [2:0] f3;
    logic [1:0] sel_nx;
    logic run, is_br, taken, cond, mis_nx;
    logic unused_ok;
    assign unused_ok = ^{fetch_pc, res_pc, res_inst};
    assign run = state == RUN;
    assign bpu_ready = run;
    assign fidx = fetch_pc[PC_LSB +: IDXW];
    assign ridx = res_pc[PC_LSB +: IDXW];
    assign f3 = res_inst[14:12];
    assign pred_taken = run & fetch_valid & bht[fidx][CTR_BITS-1];
    always_comb begin
        state_nx = (run || ptr == LAST) ? RUN : INIT;
        taken = f3[2] ? ((f3[1] ? cmp_ltu : cmp_lt) ^ f3[0]) : (cmp_eq ^ f3[0]);
        is_br = run & res_valid & (res_inst[6:0] == 7'b1100011) & (f3[2] | ~f3[1]);
        mis_nx = is_br & (taken != res_pred_taken);
        rctr = bht[ridx];
        rctr_nx = taken ? (rctr == CTR_MAX ? rctr : rctr + 1'b1)
                        : (rctr == '0 ? rctr : rctr - 1'b1);
        case (select_mode)
            4'd3:    cond = cmp_lt;
            4'd4:    cond = ~cmp_lt;
            4'd5:    cond = cmp_eq;
            4'd6:    cond = ~cmp_eq;
            4'd7:    cond = cmp_ltu;
            4'd8:    cond = ~cmp_ltu;
            default: cond = 1'b0;
        endcase
        sel_nx = !(run && res_valid) ? 2'b00
               : (select_mode == 4'd1 || select_mode == 4'd2) ? select_mode[1:0]
               : {1'b0, cond};
    end
    // Table has no reset: the INIT sweep rewrites every entry after each reset.
    always_ff @(posedge clk) begin
        if (!run)
            bht[ptr] <= CTR_INIT;
        else if (is_br)
            bht[ridx] <= rctr_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            ptr        <= '0;
            pc_sel     <= 2'b00;
            mispredict <= 1'b0;
            flush      <= 1'b0;
        end else begin
            state      <= state_nx;
            ptr        <= run ? ptr : ptr + 1'b1;
            pc_sel     <= sel_nx;
            mispredict <= mis_nx;
            flush      <= mis_nx;
        end
    end
`ifdef BPU_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (is_br && stat_branches != '1)
                stat_branches <= stat_branches + 1'b1;
            if (mis_nx && stat_mispredicts != '1)
                stat_mispredicts <= stat_mispredicts + 1'b1;
        end
    end
`else
    assign stat_branches = '0;
    assign stat_mispredicts = '0;
`endif
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed checks of init sweep, prediction, training, pc_sel and reset
module tb_branch_predict_unit;
    logic clk = 1'b0, rst_n = 1'b0;
    logic fetch_valid = 1'b0, res_valid = 1'b0, res_pred_taken = 1'b0;
    logic [31:0] fetch_pc = '0, res_pc = '0, res_inst = '0;
    logic cmp_eq = 1'b0, cmp_lt = 1'b0, cmp_ltu = 1'b0;
    logic [3:0] select_mode = '0;
    logic pred_taken, bpu_ready, mispredict, flush;
    logic [1:0] pc_sel;
    logic [31:0] stat_branches, stat_mispredicts;
    int n_tests = 0, n_fail = 0;

    branch_predict_unit dut (
        .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .bpu_ready(bpu_ready), .res_valid(res_valid),
        .res_inst(res_inst), .res_pc(res_pc), .res_pred_taken(res_pred_taken),
        .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .cmp_ltu(cmp_ltu), .select_mode(select_mode),
        .pc_sel(pc_sel), .mispredict(mispredict), .flush(flush),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic br(input logic [2:0] f3, input logic [31:0] pc, input logic eq, input logic lt,
                      input logic ltu, input logic pt, input logic [3:0] mode);
        res_valid = 1'b1;
        res_inst = {17'd0, f3, 5'd0, 7'b1100011};
        res_pc = pc;
        cmp_eq = eq;
        cmp_lt = lt;
        cmp_ltu = ltu;
        res_pred_taken = pt;
        select_mode = mode;
    endtask

    task automatic resolve_check(input string tag, input logic mis, input logic [1:0] sel);
        step();
        res_valid = 1'b0;
        check({tag, "_mis"}, 32'(mispredict), 32'(mis));
        check({tag, "_flush"}, 32'(flush), 32'(mis));
        check({tag, "_pcsel"}, 32'(pc_sel), 32'(sel));
    endtask

    task automatic predict(input string tag, input logic [31:0] pc, input logic exp);
        fetch_valid = 1'b1;
        fetch_pc = pc;
        #1;
        check(tag, 32'(pred_taken), 32'(exp));
    endtask

    task automatic init_sweep(input string tag);
        for (int i = 0; i < 64; i++) begin
            check({tag, "_ready_init"}, 32'(bpu_ready), 32'd0);
            check({tag, "_pred_init"}, 32'(pred_taken), 32'd0);
            step();
            if (i < 63) begin
                check({tag, "_mis_init"}, 32'(mispredict), 32'd0);
                check({tag, "_pcsel_init"}, 32'(pc_sel), 32'd0);
            end
        end
        res_valid = 1'b0;
        check({tag, "_ready_run"}, 32'(bpu_ready), 32'd1);
    endtask

    initial begin
        #1;
        check("rst_ready", 32'(bpu_ready), 32'd0);
        check("rst_mis", 32'(mispredict), 32'd0);
        check("rst_pcsel", 32'(pc_sel), 32'd0);
        check("rst_stat_br", stat_branches, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        fetch_valid = 1'b1;
        fetch_pc = 32'h100;
        br(3'b000, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
        init_sweep("a");

        predict("beq_pre", 32'h100, 1'b0);
        br(3'b000, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
        resolve_check("beq", 1'b1, 2'b01);
        predict("beq_post", 32'h100, 1'b1);
        step();
        check("beq_mis_clr", 32'(mispredict), 32'd0);
        check("beq_flush_clr", 32'(flush), 32'd0);
        check("idle_pcsel", 32'(pc_sel), 32'd0);

        br(3'b100, 32'h204, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
        resolve_check("blt1", 1'b1, 2'b01);
        for (int i = 0; i < 3; i++) begin
            br(3'b100, 32'h204, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3);
            resolve_check("bltn", 1'b0, 2'b01);
        end
        br(3'b100, 32'h204, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
        resolve_check("blt_nt1", 1'b1, 2'b00);
        predict("blt_sat", 32'h204, 1'b1);
        br(3'b100, 32'h204, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
        resolve_check("blt_nt2", 1'b1, 2'b00);
        predict("blt_weak", 32'h204, 1'b0);

        br(3'b010, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 4'd11);
        resolve_check("f3_010", 1'b0, 2'b00);
        br(3'b011, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        resolve_check("f3_011", 1'b0, 2'b00);
        predict("nonbr_keep", 32'h100, 1'b1);
        br(3'b010, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
        resolve_check("mode_jalr", 1'b0, 2'b10);
        br(3'b010, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        resolve_check("mode_jal", 1'b0, 2'b01);
        br(3'b010, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8);
        resolve_check("mode_geu", 1'b0, 2'b01);
        br(3'b010, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 4'd6);
        resolve_check("mode_ne", 1'b0, 2'b00);
        fetch_valid = 1'b0;
        #1;
        check("fetch_invalid", 32'(pred_taken), 32'd0);

        predict("bge_same_pre", 32'h308, 1'b0);
        br(3'b101, 32'h308, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
        #1;
        check("bge_same_cycle", 32'(pred_taken), 32'd0);
        resolve_check("bge", 1'b1, 2'b01);
        predict("bge_post", 32'h308, 1'b1);
        predict("alias_idx", 32'h108, 1'b1);

        br(3'b001, 32'h308, 1'b1, 1'b0, 1'b0, 1'b1, 4'd6);
        resolve_check("bne1", 1'b1, 2'b00);
        br(3'b001, 32'h308, 1'b1, 1'b0, 1'b0, 1'b0, 4'd6);
        resolve_check("bne2", 1'b0, 2'b00);
        br(3'b111, 32'h308, 1'b0, 1'b0, 1'b1, 1'b0, 4'd8);
        resolve_check("bgeu", 1'b0, 2'b00);
        br(3'b110, 32'h308, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7);
        resolve_check("bltu1", 1'b1, 2'b01);
        predict("floor_sat", 32'h308, 1'b0);
        br(3'b110, 32'h308, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7);
        resolve_check("bltu2", 1'b1, 2'b01);
        predict("bltu_post", 32'h308, 1'b1);

`ifdef BPU_STATS_EN
        check("stat_br", stat_branches, 32'd13);
        check("stat_mis", stat_mispredicts, 32'd8);
`else
        check("stat_br_off", stat_branches, 32'd0);
        check("stat_mis_off", stat_mispredicts, 32'd0);
`endif

        rst_n = 1'b0;
        #1;
        check("rst2_ready", 32'(bpu_ready), 32'd0);
        check("rst2_stat_br", stat_branches, 32'd0);
        check("rst2_stat_mis", stat_mispredicts, 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("midinit_ready", 32'(bpu_ready), 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        fetch_pc = 32'h100;
        init_sweep("b");
        predict("reinit_100", 32'h100, 1'b0);
        predict("reinit_308", 32'h308, 1'b0);
        predict("reinit_204", 32'h204, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
